// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter owning one shared N-bit register; 3 cycles per write, aborts cost 2.
// Optional REG_ARB_LOCK_EN adds a lock input for back-to-back writes by the current owner.
module reg_share_arbiter #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] d,
`ifdef REG_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [3:0]     gnt,
  output logic [3:0]     ack,
  output logic [N-1:0]   q,
  output logic [1:0]     owner,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t       state, state_nxt;
  logic [1:0]   ptr, ptr_nxt, owner_nxt, win;
  logic         found, lock_hold;
  logic [3:0]   gnt_nxt, ack_nxt;
  logic [N-1:0] q_nxt;

`ifdef REG_ARB_LOCK_EN
  assign lock_hold = lock & req[owner];
`else
  assign lock_hold = 1'b0;
`endif

  // First set request at or after ptr, wrapping modulo 4.
  always_comb begin
    logic [1:0] idx;
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    ack_nxt   = ack;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = 4'b0001 << win;
          owner_nxt = win;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (req[owner]) begin
          q_nxt     = d[owner*N +: N];
          ack_nxt   = 4'b0001 << owner;
          state_nxt = ACK;
        end else begin
          gnt_nxt   = 4'b0000;
          state_nxt = IDLE;
        end
      end
      ACK: begin
        ack_nxt = 4'b0000;
        // A locked owner keeps the grant and the pointer for its next write.
        if (lock_hold) begin
          state_nxt = GRANT;
        end else begin
          gnt_nxt   = 4'b0000;
          ptr_nxt   = owner + 2'd1;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = 4'b0000;
        ack_nxt   = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      gnt   <= 4'b0000;
      ack   <= 4'b0000;
      q     <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      q     <= q_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin write arbiter that shares one N-bit D-register among four requesters. It sequences every write through a grant/ack handshake, so only one requester loads the register at a time. Its registered output q feeds downstream logic exactly as a plain D-register output would. It sits between the requesting blocks and the shared register storage, and it owns that storage internally.

## Interface
- N, 4, data width of the shared register and of each requester's data slice
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  4  request vector; req[i] held high by requester i until ack[i]
- d  in  4*N  write data; slice i is d[i*N +: N], held stable while req[i] is high
- lock  in  1  present only with REG_ARB_LOCK_EN; current owner requests back-to-back writes
- gnt  out  4  one-hot grant, registered
- ack  out  4  one-hot, one-cycle write-done strobe, registered
- q  out  N  shared register contents
- owner  out  2  index of last/current grantee
- busy  out  1  high whenever state is not IDLE

## Operation
- Reset values: q=0, gnt=0, ack=0, owner=0, busy=0, round-robin pointer ptr=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-operation clears everything immediately, and any in-flight write is discarded.
- FSM states and transitions:
  - IDLE: if req != 0, pick winner w = the first set req bit searching ptr, ptr+1, ... mod 4. Set gnt<=onehot(w), owner<=w, go to GRANT. If req == 0, stay.
  - GRANT:
    - If req[w] is still high: q<=d slice w, ack[w]<=1, go to ACK.
    - If req[w] has dropped (abort): gnt<=0, q unchanged, ptr unchanged, go to IDLE.
  - ACK: ack<=0, gnt<=0, ptr<=(w+1) mod 4, go to IDLE.
- q changes only on a GRANT->ACK transition. It otherwise holds its value indefinitely.
- Requester i must drop req[i] in the cycle it sees ack[i]. If req[i] is still high in IDLE, it is treated as a new request and competes normally under round-robin.
- Only gnt owner's data is ever sampled. Data on non-granted slices is ignored.
- Simultaneous requests: the lowest index at or after ptr wins, and all others wait. Every active requester is served within 4 grants.
- Requests arriving during GRANT/ACK are not sampled until IDLE.

## Timing
- req sampled high at edge k: gnt high after k+1, q/ack updated after k+2, gnt/ack low after k+3.
- Throughput: one write per 3 cycles. The earliest next grant is at edge k+4 (re-evaluated in IDLE at k+3).
- ack is exactly one cycle wide. gnt spans exactly two cycles (GRANT and ACK).
- busy is high after k+1 through k+3 inclusive.
- An abort in GRANT costs 2 cycles, with no ack and no q change.

## Configuration
- REG_ARB_LOCK_EN defined:
  - The lock port exists.
  - In ACK, if lock=1 and req[w]=1: go directly to GRANT for the same w, keeping gnt high, ptr unchanged, and ack low. The next write lands 2 cycles after the previous one.
  - If lock=0, behaviour is unchanged.
- REG_ARB_LOCK_EN undefined: the lock port is absent and ACK always returns to IDLE.

## Test plan
- Reset then idle: reset_n low for 15 ns, then high with req=0 for 10 cycles -> q=0, gnt=0, ack=0, busy=0 throughout.
- Single write: N=4, req=4'b0100, d slice2=4'hA -> gnt=4'b0100 at +1, q=4'hA and ack=4'b0100 at +2, all low at +3.
- Round-robin fairness: req=4'b1111 held with slices 1,2,3,4 and each requester re-requesting after its ack -> grant order 0,1,2,3,0 and q sequence 1,2,3,4,1.
- Abort: req=4'b0001, drop req in GRANT -> no ack, q unchanged, next grant again goes to requester 0 (ptr not advanced).
- Reset mid-write: assert reset_n=0 during GRANT with d=4'hF -> q=0, gnt=0, state IDLE; no ack ever issued.
- Lock (REG_ARB_LOCK_EN): req[1]=1, lock=1 with data 5 then 6 -> q=5, then q=6 two cycles later, gnt[1] high continuously, ack pulses on each write.
